// File: rtl/calc_pkg.sv
// calc_pkg: widths, saturation limit and FSM states shared by the ZSSD engine and the comparator
package calc_pkg;
    localparam int RANK_W = 6;
    localparam int ZSSD_W = 32;
    localparam logic [ZSSD_W-1:0] ZSSD_MAX = '1;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC,
        ST_FIN,
        ST_OUT,
        ST_END
    } state_e;
endpackage

// File: rtl/calc_zssd_serial_if.sv
// calc_zssd_serial_if: pixel-pair stream in, per-rank ZSSD result out
interface calc_zssd_serial_if #(parameter int PIX_W = 8);
    import calc_pkg::*;
    logic              clear;
    logic              pix_valid;
    logic              pix_ready;
    logic [PIX_W-1:0]  pix_l;
    logic [PIX_W-1:0]  pix_r;
    logic [RANK_W-1:0] rank;
    logic [ZSSD_W-1:0] zssd;
    logic              compable;
    logic              windowend;
    modport master (
        output clear, pix_valid, pix_l, pix_r,
        input  pix_ready, rank, zssd, compable, windowend
    );
    modport slave (
        input  clear, pix_valid, pix_l, pix_r,
        output pix_ready, rank, zssd, compable, windowend
    );
endinterface

// File: rtl/calc_zssd_accum.sv
// calc_zssd_accum: per-window sum of differences, sum of squared differences and pixel count
module calc_zssd_accum #(
    parameter int WIN_LOG2 = 6,
    parameter int PIX_W    = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic                             clr,
    input  logic [PIX_W-1:0]                 pix_l,
    input  logic [PIX_W-1:0]                 pix_r,
    output logic signed [PIX_W+WIN_LOG2:0]   sum_d,
    output logic [2*PIX_W+WIN_LOG2-1:0]      sum_sq,
    output logic                             last
);
    localparam logic [WIN_LOG2:0] CNT_LAST = (WIN_LOG2+1)'((1 << WIN_LOG2) - 1);
    logic signed [PIX_W:0]     d;
    logic signed [2*PIX_W-1:0] d_x;
    logic [2*PIX_W-1:0]        d_sq;
    logic [WIN_LOG2:0]         cnt;
    assign d    = $signed({1'b0, pix_l}) - $signed({1'b0, pix_r});
    assign d_x  = (2*PIX_W)'(d);
    assign d_sq = $unsigned(d_x * d_x);
    assign last = en && cnt == CNT_LAST;
    // accumulate one pair per accepted transfer; clr restarts the window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_d  <= '0;
            sum_sq <= '0;
            cnt    <= '0;
        end else if (clr) begin
            sum_d  <= '0;
            sum_sq <= '0;
            cnt    <= '0;
        end else if (en) begin
            sum_d  <= sum_d + (PIX_W+1+WIN_LOG2)'(d);
            sum_sq <= sum_sq + (2*PIX_W+WIN_LOG2)'(d_sq);
            cnt    <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/calc_zssd_serial.sv
// calc_zssd_serial: serial zero-mean SSD per disparity rank with compable/windowend strobes
module calc_zssd_serial
    import calc_pkg::*;
#(
    parameter int MAX_DISP = 64,
    parameter int WIN_LOG2 = 6,
    parameter int PIX_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    calc_zssd_serial_if.slave    bus
);
    localparam int SD_W = PIX_W + 1 + WIN_LOG2;
    localparam int SQ_W = 2*PIX_W + WIN_LOG2;
    localparam int P_W  = 2*SD_W;
    localparam int C_W  = P_W + ZSSD_W;
    localparam logic [RANK_W-1:0] RANK_LAST = RANK_W'(MAX_DISP - 1);
    logic signed [SD_W-1:0] sum_d;
    logic [SQ_W-1:0]        sum_sq;
    logic                   last;
    logic                   en;
    logic                   clr;
    logic signed [P_W-1:0]  sd_x;
    logic signed [P_W-1:0]  sd_sq;
    logic [C_W-1:0]         diff;
    logic [ZSSD_W-1:0]      zssd_n;
    state_e                 state;
    state_e                 nxt;
    assign en     = bus.pix_ready && bus.pix_valid && !bus.clear;
    assign clr    = bus.clear || state == ST_OUT;
    assign sd_x   = P_W'(sum_d);
    assign sd_sq  = sd_x * sd_x;
    assign diff   = C_W'(sum_sq) - (C_W'($unsigned(sd_sq)) >> WIN_LOG2);
    assign zssd_n = |diff[C_W-1:ZSSD_W] ? ZSSD_MAX : diff[ZSSD_W-1:0];
    calc_zssd_accum #(.WIN_LOG2(WIN_LOG2), .PIX_W(PIX_W)) u_accum (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .clr    (clr),
        .pix_l  (bus.pix_l),
        .pix_r  (bus.pix_r),
        .sum_d  (sum_d),
        .sum_sq (sum_sq),
        .last   (last)
    );
    // next state; clear overrides everything and restarts accumulation
    always_comb begin
        nxt = bus.clear          ? ST_ACC :
              state == ST_ACC    ? (last ? ST_FIN : ST_ACC) :
              state == ST_FIN    ? ST_OUT :
              state == ST_OUT    ? (bus.rank == RANK_LAST ? ST_END : ST_ACC) :
                                   ST_ACC;
    end
    // state, registered strobes/ready decoded from the next state, rank counter and result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            bus.pix_ready <= 1'b0;
            bus.compable  <= 1'b0;
            bus.windowend <= 1'b0;
            bus.rank      <= '0;
            bus.zssd      <= '0;
        end else begin
            state         <= nxt;
            bus.pix_ready <= nxt == ST_ACC;
            bus.compable  <= nxt == ST_OUT;
            bus.windowend <= nxt == ST_END;
            bus.rank      <= (bus.clear || state == ST_END) ? '0 :
                             (state == ST_OUT && bus.rank != RANK_LAST) ? bus.rank + 1'b1 : bus.rank;
            if (state == ST_FIN && !bus.clear)
                bus.zssd <= zssd_n;
        end
    end
endmodule

// File: tb/tb_calc_zssd_serial.sv
// tb_calc_zssd_serial: scoreboard-driven checks of ZSSD values, strobes, clear and reset behaviour
module tb_calc_zssd_serial;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int passed = 0;
    int exp_rank = 0;
    int we_cnt = 0;
    int q_rank[$];
    longint q_zssd[$];
    logic prev63 = 1'b0;
    int er;
    longint ez;

    calc_zssd_serial_if #(.PIX_W(8)) bus ();

    calc_zssd_serial #(.MAX_DISP(64), .WIN_LOG2(6), .PIX_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // scoreboard: every compable pops one expected result; windowend must follow rank 63 by one cycle
    always @(negedge clk) begin
        if (reset) begin
            prev63 = 1'b0;
        end else begin
            if (bus.compable) begin
                if (q_rank.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_compable: got rank=%0d zssd=%0d, expected no strobe", bus.rank, bus.zssd);
                end else begin
                    er = q_rank.pop_front();
                    ez = q_zssd.pop_front();
                    checks++;
                    if (bus.rank !== 6'(er)) $display("FAIL result_rank: got %0d, expected %0d", bus.rank, er);
                    else passed++;
                    checks++;
                    if (bus.zssd !== 32'(ez)) $display("FAIL result_zssd rank %0d: got %0d, expected %0d", er, bus.zssd, ez);
                    else passed++;
                end
            end
            if (bus.windowend) we_cnt++;
            if (bus.windowend || prev63) begin
                checks++;
                if (bus.windowend !== prev63 || bus.compable)
                    $display("FAIL windowend_timing: got windowend=%0b compable=%0b, expected windowend=%0b compable=0", bus.windowend, bus.compable, prev63);
                else passed++;
            end
            prev63 = bus.compable && bus.rank == 6'd63;
        end
    end

    task automatic put(input logic [7:0] l, input logic [7:0] r);
        int n = 0;
        bus.pix_valid = 1'b1;
        bus.pix_l = l;
        bus.pix_r = r;
        while (!bus.pix_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL put_timeout: got pix_ready=0 for %0d cycles, expected 1", n);
        end
        @(negedge clk);
    endtask

    task automatic send_window(input int mode, input int gap, input bit chk);
        logic [7:0] ls[64];
        logic [7:0] rs[64];
        longint sd = 0;
        longint sq = 0;
        int d;
        bit last_rank;
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0: begin ls[i] = 8'd37; rs[i] = 8'd37; end
                1: begin ls[i] = 8'd100; rs[i] = 8'd90; end
                2: begin ls[i] = (i % 2) ? 8'd90 : 8'd100; rs[i] = (i % 2) ? 8'd100 : 8'd90; end
                3: begin ls[i] = 8'd255; rs[i] = 8'd0; end
                default: begin ls[i] = 8'($urandom_range(0, 255)); rs[i] = 8'($urandom_range(0, 255)); end
            endcase
            d = int'(ls[i]) - int'(rs[i]);
            sd += d;
            sq += d * d;
        end
        q_rank.push_back(exp_rank);
        q_zssd.push_back(sq - ((sd * sd) >> 6));
        last_rank = exp_rank == 63;
        exp_rank = (exp_rank + 1) % 64;
        for (int i = 0; i < 64; i++) begin
            if (gap > 0) begin
                bus.pix_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            put(ls[i], rs[i]);
        end
        bus.pix_valid = 1'b0;
        if (chk) begin
            checks++;
            if (bus.compable !== 1'b0 || bus.pix_ready !== 1'b0)
                $display("FAIL fin_cycle: got compable=%0b pix_ready=%0b, expected 0/0", bus.compable, bus.pix_ready);
            else passed++;
            @(negedge clk);
            checks++;
            if (bus.compable !== 1'b1 || bus.pix_ready !== 1'b0)
                $display("FAIL out_cycle: got compable=%0b pix_ready=%0b, expected 1/0", bus.compable, bus.pix_ready);
            else passed++;
            @(negedge clk);
            if (last_rank) begin
                checks++;
                if (bus.windowend !== 1'b1 || bus.pix_ready !== 1'b0)
                    $display("FAIL end_cycle: got windowend=%0b pix_ready=%0b, expected 1/0", bus.windowend, bus.pix_ready);
                else passed++;
                @(negedge clk);
            end
            checks++;
            if (bus.pix_ready !== 1'b1)
                $display("FAIL ready_return: got pix_ready=%0b, expected 1", bus.pix_ready);
            else passed++;
        end
    endtask

    task automatic test_reset();
        bus.clear = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_l = '0;
        bus.pix_r = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rank !== 6'd0 || bus.zssd !== 32'd0 || bus.compable !== 1'b0 || bus.windowend !== 1'b0 || bus.pix_ready !== 1'b0)
            $display("FAIL reset_values: got rank=%0d zssd=%0d comp=%0b we=%0b rdy=%0b, expected all 0",
                     bus.rank, bus.zssd, bus.compable, bus.windowend, bus.pix_ready);
        else passed++;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.pix_ready !== 1'b0) $display("FAIL ready_after_release: got %0b, expected 0", bus.pix_ready);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.pix_ready !== 1'b1) $display("FAIL ready_idle_to_acc: got %0b, expected 1", bus.pix_ready);
        else passed++;
    endtask

    task automatic test_identical();
        send_window(0, 0, 1);
        for (int k = 1; k < 63; k++) send_window(0, 0, 0);
        send_window(0, 0, 1);
        repeat (3) @(negedge clk);
        checks++;
        if (we_cnt !== 1) $display("FAIL windowend_count: got %0d, expected 1", we_cnt);
        else passed++;
    endtask

    task automatic test_zero_mean();
        send_window(1, 0, 1);
    endtask

    task automatic test_alternating();
        send_window(2, 0, 1);
        send_window(3, 0, 1);
    endtask

    task automatic test_sparse();
        send_window(4, 2, 1);
        send_window(2, 2, 1);
        send_window(1, 2, 1);
    endtask

    task automatic test_clear();
        while (exp_rank != 5) send_window(4, 0, 0);
        for (int i = 0; i < 20; i++) put(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        bus.pix_valid = 1'b1;
        bus.pix_l = 8'd255;
        bus.pix_r = 8'd0;
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        bus.pix_valid = 1'b0;
        exp_rank = 0;
        checks++;
        if (bus.rank !== 6'd0 || bus.pix_ready !== 1'b1)
            $display("FAIL clear_state: got rank=%0d pix_ready=%0b, expected 0/1", bus.rank, bus.pix_ready);
        else passed++;
        repeat (5) @(negedge clk);
        send_window(4, 0, 1);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        send_window(4, 0, 0);
        while (!bus.compable && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) $display("FAIL wait_compable: got no strobe in %0d cycles, expected one", n);
        else passed++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.compable !== 1'b0 || bus.rank !== 6'd0 || bus.zssd !== 32'd0 || bus.pix_ready !== 1'b0 || bus.windowend !== 1'b0)
            $display("FAIL async_reset: got comp=%0b rank=%0d zssd=%0d rdy=%0b we=%0b, expected all 0",
                     bus.compable, bus.rank, bus.zssd, bus.pix_ready, bus.windowend);
        else passed++;
        q_rank.delete();
        q_zssd.delete();
        exp_rank = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.pix_ready !== 1'b0) $display("FAIL ready_after_mid_reset: got %0b, expected 0", bus.pix_ready);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.pix_ready !== 1'b1) $display("FAIL ready_rise_mid_reset: got %0b, expected 1", bus.pix_ready);
        else passed++;
        send_window(2, 0, 1);
    endtask

    initial begin
        test_reset();
        test_identical();
        test_zero_mean();
        test_alternating();
        test_sparse();
        test_clear();
        test_reset_mid();
        repeat (5) @(negedge clk);
        checks++;
        if (q_rank.size() !== 0) $display("FAIL results_outstanding: got %0d pending, expected 0", q_rank.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
